regfile_sb: RTL

- Parametrised register file for the 16-bit pipelined core: two combinational read ports, one write port with write-to-read bypass, and an optional hard-wired zero register.
- Adds a per-register busy scoreboard so the issue stage can detect read-after-write hazards.
- Adds a single-entry checkpoint shadow bank for interrupt entry/return and branch recovery.
- Sits between decode/issue and writeback.

---
 rtl/core_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 49 ++++
 rtl/regfile_sb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Core-wide constants shared by the register file, decode and the hazard unit.
package core_pkg;

  localparam int CORE_DATA_W = 16;
  localparam int CORE_ADDR_W = 3;
  localparam int REG_ZERO    = 0;

endpackage : core_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets a bit, writeback clears it, restore flushes all.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int ADDR_W   = core_pkg::CORE_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_any
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-cycle issue to the written register stays busy.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    if (ZERO_REG) busy_d[REG_ZERO] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a   = busy_q[rd_addr_a];
  assign busy_b   = busy_q[rd_addr_b];
  assign busy_any = |busy_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Register file with write-to-read bypass, busy scoreboard and a one-deep checkpoint bank.
module regfile_sb
  import core_pkg::*;
#(
  parameter int DATA_W   = core_pkg::CORE_DATA_W,
  parameter int ADDR_W   = core_pkg::CORE_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  input  logic              ckpt_save,
  input  logic              ckpt_restore,
  output logic              ckpt_valid,
  output logic              restore_err,
  output logic              busy_any
);

  localparam int                NREGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q   [NREGS];
  logic [DATA_W-1:0] regs_d   [NREGS];
  logic [DATA_W-1:0] shadow_q [NREGS];
  logic [DATA_W-1:0] shadow_d [NREGS];
  logic [DATA_W-1:0] wr_image [NREGS];
  logic              ckpt_valid_q, ckpt_valid_d;
  logic              restore_err_q, restore_err_d;
  logic              wr_ok, do_restore, do_save;
  logic              sb_busy_a, sb_busy_b;

  assign wr_ok      = wr_en && !(ZERO_REG && (wr_addr == ZERO_A));
  assign do_restore = ckpt_restore && ckpt_valid_q;
  assign do_save    = ckpt_save && !ckpt_restore;

  // The post-write image feeds both the next architectural state and the checkpoint.
  always_comb begin
    wr_image = regs_q;
    if (wr_ok) wr_image[wr_addr] = wr_data;
    if (do_restore) regs_d = shadow_q;
    else            regs_d = wr_image;
    if (do_save) shadow_d = wr_image;
    else         shadow_d = shadow_q;
    ckpt_valid_d  = ckpt_valid_q || do_save;
    restore_err_d = ckpt_restore && !ckpt_valid_q;
  end

  // NOTE: the storage array is reset explicitly because the bench and the zero register rely on a known image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      ckpt_valid_q  <= 1'b0;
      restore_err_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      shadow_q      <= shadow_d;
      ckpt_valid_q  <= ckpt_valid_d;
      restore_err_q <= restore_err_d;
    end
  end

  // A discarded restore-cycle write still pulses clr_en, but flush overrides it.
  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_en),
    .set_addr  (iss_addr),
    .clr_en    (wr_ok),
    .clr_addr  (wr_addr),
    .flush     (do_restore),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .busy_a    (sb_busy_a),
    .busy_b    (sb_busy_b),
    .busy_any  (busy_any)
  );

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_busy_a = sb_busy_a;
    if (BYPASS && wr_ok && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      rd_busy_a = 1'b0;
    end
    if (ZERO_REG && (rd_addr_a == ZERO_A)) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    rd_busy_b = sb_busy_b;
    if (BYPASS && wr_ok && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      rd_busy_b = 1'b0;
    end
    if (ZERO_REG && (rd_addr_b == ZERO_A)) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end
  end

  assign ckpt_valid  = ckpt_valid_q;
  assign restore_err = restore_err_q;

endmodule : regfile_sb
